// File: rtl/dram_emu_pkg.sv
// Shared types and constants for the DRAM array emulator: FSM states, lane width, defaults.
package dram_emu_pkg;
  localparam int LANES        = 16;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_READ_LAT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    ARMED   = 2'd2,
    RD_WAIT = 2'd3
  } state_e;
endpackage

// File: rtl/dram_array_emu_if.sv
// Pin-level bundle of the emulated DRAM macro; the controller drives master, the emulator is slave.
interface dram_array_emu_if;
  import dram_emu_pkg::*;

  logic             ADDIN_1v8;
  logic             ADVLD_1v8;
  logic [LANES-1:0] DIN_1v8;
  logic             DVLD_1v8;
  logic             WRIEN_1v8;
  logic             RDEN_1v8;
  logic             DMX2_1v8;
  logic [LANES-1:0] ROUT_1v8;
  logic             ROUT_VLD;
  logic             BSY;

  modport master (
    output ADDIN_1v8, ADVLD_1v8, DIN_1v8, DVLD_1v8, WRIEN_1v8, RDEN_1v8, DMX2_1v8,
    input  ROUT_1v8, ROUT_VLD, BSY
  );

  modport slave (
    input  ADDIN_1v8, ADVLD_1v8, DIN_1v8, DVLD_1v8, WRIEN_1v8, RDEN_1v8, DMX2_1v8,
    output ROUT_1v8, ROUT_VLD, BSY
  );
endinterface

// File: rtl/dram_emu_rowbank.sv
// ROWS x 16 register file: one synchronous write port, two combinational read ports, async clear.
module dram_emu_rowbank
  import dram_emu_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LANES-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [LANES-1:0]  rdata_a,
  output logic [LANES-1:0]  rdata_b
);
  logic [LANES-1:0] mem [ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/dram_array_emu.sv
// DRAM array emulator: serial row address, single-row write, fixed-latency read.
// Define CIM_XOR_EN to enable the in-array XOR read (row[a] ^ row[a^1]) selected by DMX2_1v8.
//
// state   | meaning
// IDLE    | waiting for the first address bit
// ADDR    | shifting serial address bits, MSB first
// ARMED   | row address latched, waiting for write or read
// RD_WAIT | read in flight, inputs ignored, BSY high
module dram_array_emu
  import dram_emu_pkg::*;
#(
  parameter int ROWS     = 16,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic             CLK,
  input  logic             RSTn,
  dram_array_emu_if.slave  bus
);
  localparam int CNT_W = $clog2(ADDR_W + 1);

  state_e            state_q;
  logic [ADDR_W-1:0] shift_q, addr_q, shift_nxt;
  logic [CNT_W-1:0]  bits_left_q;
  logic [2:0]        lat_q;
  logic              dmx_q;
  logic [LANES-1:0]  rout_q, row_a, row_b, result;
  logic              vld_q, bsy_q, wr_en;

  assign shift_nxt = ADDR_W'({shift_q, bus.ADDIN_1v8});
  assign wr_en     = (state_q == ARMED) && bus.WRIEN_1v8 && bus.DVLD_1v8;

  dram_emu_rowbank #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_rowbank (
    .clk     (CLK),
    .rst_n   (RSTn),
    .we      (wr_en),
    .waddr   (addr_q),
    .wdata   (bus.DIN_1v8),
    .raddr_a (addr_q),
    .raddr_b (addr_q ^ ADDR_W'(1)),
    .rdata_a (row_a),
    .rdata_b (row_b)
  );

`ifdef CIM_XOR_EN
  assign result = dmx_q ? (row_a ^ row_b) : row_a;
`else
  logic unused_dmx;
  assign unused_dmx = dmx_q ^ (|row_b);
  assign result     = row_a;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      addr_q      <= '0;
      bits_left_q <= '0;
      lat_q       <= '0;
      dmx_q       <= 1'b0;
      rout_q      <= '0;
      vld_q       <= 1'b0;
      bsy_q       <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE, ARMED: begin
          // In ARMED a write beats a read, and either beats a new address.
          if (wr_en) begin
            state_q <= IDLE;
          end else if (state_q == ARMED && bus.RDEN_1v8) begin
            dmx_q   <= bus.DMX2_1v8;
            lat_q   <= 3'(READ_LAT - 1);
            bsy_q   <= 1'b1;
            state_q <= RD_WAIT;
          end else if (bus.ADVLD_1v8) begin
            shift_q     <= shift_nxt;
            bits_left_q <= CNT_W'(ADDR_W - 1);
            if (ADDR_W == 1) begin
              addr_q  <= shift_nxt;
              state_q <= ARMED;
            end else begin
              state_q <= ADDR;
            end
          end
        end
        ADDR: begin
          if (!bus.ADVLD_1v8) begin
            bits_left_q <= '0;
            state_q     <= IDLE;
          end else begin
            shift_q <= shift_nxt;
            if (bits_left_q == CNT_W'(1)) begin
              addr_q      <= shift_nxt;
              bits_left_q <= '0;
              state_q     <= ARMED;
            end else begin
              bits_left_q <= bits_left_q - 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (lat_q == 3'd0) begin
            rout_q  <= result;
            vld_q   <= 1'b1;
            bsy_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ROUT_1v8 = rout_q;
  assign bus.ROUT_VLD = vld_q;
  assign bus.BSY      = bsy_q;
endmodule
